// File: rtl/dlx_dram_responder.sv
// Memory-side responder for the DLX data-memory handshake: word-addressed storage,
// programmable wait states, and a data bus driven only while returning read data.
module dlx_dram_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic                  ENABLE,
  input  logic                  READNOTWRITE,
  output logic                  DATA_READY,
  inout  wire  [DATA_WIDTH-1:0] INOUT_DATA,
  output logic                  err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int   IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic HAS_WAIT = (LATENCY > 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    rnw_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [CNT_WIDTH-1:0]    rd_count_reg, wr_count_reg;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic                    commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic                    c_rnw;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic                    c_err;
  logic [IDX_W-1:0]        c_idx;
  logic                    drive;
  logic [DATA_WIDTH-1:0]   rd_out;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; dropping ENABLE in WAIT wins over reaching the last wait cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (ENABLE) state_next = HAS_WAIT ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!ENABLE)              state_next = S_IDLE;
        else if (cnt_reg == 4'd1) state_next = S_RESP;
      end
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero latency the commit edge is the accept edge, so use the live request
  always_comb begin
    c_addr  = (state_reg == S_IDLE) ? ADDRESS      : addr_reg;
    c_rnw   = (state_reg == S_IDLE) ? READNOTWRITE : rnw_reg;
    c_wdata = (state_reg == S_IDLE) ? INOUT_DATA   : wdata_reg;
    c_idx   = c_addr[IDX_W+1:2];
    c_err   = (|c_addr[1:0]) || ((c_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));
    commit  = rst && (state_next == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (state_reg == S_IDLE && ENABLE) begin
        addr_reg <= ADDRESS;
        rnw_reg  <= READNOTWRITE;
        if (!READNOTWRITE) wdata_reg <= INOUT_DATA;
        cnt_reg  <= 4'(LATENCY);
      end else if (state_reg == S_WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (commit) err_reg <= c_err;
      if (state_reg == S_RESP) begin
        if (rnw_reg) rd_count_reg <= rd_count_reg + CNT_WIDTH'(1);
        else         wr_count_reg <= wr_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Storage with registered read; error reads are zeroed on the output side
  always_ff @(posedge clk) begin
    if (commit && !c_rnw && !c_err) mem[c_idx] <= c_wdata;
    if (commit && c_rnw)            rdata_reg  <= mem[c_idx];
  end

  // Output logic
  always_comb begin
    DATA_READY = (state_reg == S_RESP);
    err        = (state_reg == S_RESP) && err_reg;
    busy       = (state_reg != S_IDLE);
    drive      = (state_reg == S_RESP) && rnw_reg;
    rd_out     = err_reg ? '0 : rdata_reg;
    rd_count   = rd_count_reg;
    wr_count   = wr_count_reg;
  end

  assign INOUT_DATA = drive ? rd_out : 'z;

endmodule

// File: tb/tb_dlx_dram_responder.sv
// Scoreboard bench: stimulus queues expected responses, per-instance monitors
// compare them whenever DATA_READY is presented.
module tb_dlx_dram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic        en0, rnw0, drv0, en1, rnw1, drv1;
  wire  [31:0] bus0, bus1;
  logic        rdy0, err0, busy0, rdy1, err1, busy1;
  logic [15:0] rdc0, wrc0, rdc1, wrc1;

  assign bus0 = drv0 ? wd0 : 'z;
  assign bus1 = drv1 ? wd1 : 'z;

  dlx_dram_responder #(.LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .ADDRESS(addr0), .ENABLE(en0), .READNOTWRITE(rnw0),
    .DATA_READY(rdy0), .INOUT_DATA(bus0), .err(err0), .busy(busy0),
    .rd_count(rdc0), .wr_count(wrc0));

  dlx_dram_responder #(.LATENCY(0)) u1 (
    .clk(clk), .rst(rst), .ADDRESS(addr1), .ENABLE(en1), .READNOTWRITE(rnw1),
    .DATA_READY(rdy1), .INOUT_DATA(bus1), .err(err1), .busy(busy1),
    .rd_count(rdc1), .wr_count(wrc1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int exp_rd0 = 0, exp_wr0 = 0;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          cycle;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, ei;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk) begin
    if (rdy0) begin
      if (q0.size() == 0) check("u0 unexpected ready", 32'(rdy0), 32'd0);
      else begin
        e0 = q0.pop_front();
        check("u0 ready cycle", 32'(cyc), 32'(e0.cycle));
        check("u0 err", 32'(err0), 32'(e0.err));
        if (e0.rd) check("u0 read data", bus0, e0.data);
        $display("u0 %s done cycle %0d err=%0d bus=%h", e0.rd ? "read " : "write", cyc, err0, bus0);
      end
    end else if (err0) check("u0 err without ready", 32'(err0), 32'd0);
  end

  always @(negedge clk) begin
    if (rdy1) begin
      if (q1.size() == 0) check("u1 unexpected ready", 32'(rdy1), 32'd0);
      else begin
        e1 = q1.pop_front();
        check("u1 ready cycle", 32'(cyc), 32'(e1.cycle));
        check("u1 err", 32'(err1), 32'(e1.err));
        if (e1.rd) check("u1 read data", bus1, e1.data);
        $display("u1 %s done cycle %0d err=%0d bus=%h", e1.rd ? "read " : "write", cyc, err1, bus1);
      end
    end else if (err1) check("u1 err without ready", 32'(err1), 32'd0);
  end

  // One full handshake on u0; 'post' replaces the bus value after the accept edge
  task automatic txn0(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] post, input logic xerr, input logic [31:0] xdata);
    int n;
    @(negedge clk);
    en0 = 1'b1; rnw0 = rnw; addr0 = a; wd0 = d; drv0 = !rnw;
    ei.rd = rnw; ei.data = xdata; ei.err = xerr; ei.cycle = cyc + 3;
    q0.push_back(ei);
    if (rnw) exp_rd0++; else exp_wr0++;
    @(negedge clk);
    wd0 = post;
    addr0 = 32'h0000_0FFC; rnw0 = !rnw;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("u0 ready seen", 32'(rdy0), 32'd1);
    en0 = 1'b0; drv0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic counts0(input string tag);
    check({tag, " rd_count"}, 32'(rdc0), 32'(exp_rd0));
    check({tag, " wr_count"}, 32'(wrc0), 32'(exp_wr0));
  endtask

  initial begin
    rst = 1'b0;
    en0 = 1'b0; rnw0 = 1'b0; addr0 = '0; wd0 = '0; drv0 = 1'b0;
    en1 = 1'b0; rnw1 = 1'b0; addr1 = '0; wd1 = '0; drv1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset DATA_READY", 32'(rdy0), 32'd0);
    check("reset err", 32'(err0), 32'd0);
    check("reset busy", 32'(busy0), 32'd0);
    counts0("reset");
    rst = 1'b1;

    txn0(1'b0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0);
    txn0(1'b1, 32'h10, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    counts0("after first pair");

    txn0(1'b0, 32'h40, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 32'h0);

    // Write abandoned in WAIT
    @(negedge clk);
    en0 = 1'b1; rnw0 = 1'b0; addr0 = 32'h40; wd0 = 32'h12345678; drv0 = 1'b1;
    @(negedge clk);
    check("abort busy in wait", 32'(busy0), 32'd1);
    en0 = 1'b0; drv0 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy after", 32'(busy0), 32'd0);
    counts0("after abort");
    txn0(1'b1, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0BADF00D);

    txn0(1'b1, 32'h13, 32'h0, 32'h0, 1'b1, 32'h0);
    txn0(1'b0, 32'h1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0);
    txn0(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    txn0(1'b0, 32'h80, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h0);
    txn0(1'b1, 32'h80, 32'h0, 32'h0, 1'b0, 32'hAAAAAAAA);
    counts0("before reset");

    // Reset during a read's wait states
    @(negedge clk);
    en0 = 1'b1; rnw0 = 1'b1; addr0 = 32'h10;
    @(negedge clk);
    rst = 1'b0; en0 = 1'b0;
    @(negedge clk);
    exp_rd0 = 0; exp_wr0 = 0;
    check("mid reset DATA_READY", 32'(rdy0), 32'd0);
    check("mid reset busy", 32'(busy0), 32'd0);
    counts0("mid reset");
    rst = 1'b1;
    txn0(1'b1, 32'h10, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    counts0("after reset read");

    // Zero-latency back-to-back write then read with ENABLE held high
    @(negedge clk);
    en1 = 1'b1; rnw1 = 1'b0; addr1 = 32'h20; wd1 = 32'h0000_0001; drv1 = 1'b1;
    ei.rd = 1'b0; ei.data = 32'h0; ei.err = 1'b0; ei.cycle = cyc + 1;
    q1.push_back(ei);
    ei.rd = 1'b1; ei.data = 32'h0000_0001; ei.err = 1'b0; ei.cycle = cyc + 3;
    q1.push_back(ei);
    @(negedge clk);
    rnw1 = 1'b1; drv1 = 1'b0;
    repeat (2) @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    check("u1 rd_count", 32'(rdc1), 32'd1);
    check("u1 wr_count", 32'(wrc1), 32'd1);

    repeat (3) @(negedge clk);
    check("u0 pending responses", 32'(q0.size()), 32'd0);
    check("u1 pending responses", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dlx_dram_responder.md
Name: dlx_dram_responder

Overview:
- Responder (memory side) of the DLX data-memory interface: serves the core's DRAM_ADDRESS / DRAM_ENABLE / DRAM_READNOTWRITE / DRAM_DATA requests and returns DRAM_READY.
- Holds a word-addressed storage array, inserts a programmable number of wait states, and drives the shared bidirectional data bus only while returning read data.
- Used as the synthesizable data-memory model behind the rw memory interface in the UVM bench, and as the on-chip DRAM in FPGA builds.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, byte address width.
- DEPTH_WORDS, 1024, number of DATA_WIDTH words stored; power of two.
- LATENCY, 2, wait-state cycles between acceptance and DRAM_READY; 0..15.
- CNT_WIDTH, 16, width of the transaction counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- ADDRESS  in  ADDR_WIDTH  byte address from the core.
- ENABLE  in  1  request valid; held high until DATA_READY is seen.
- READNOTWRITE  in  1  1 = read, 0 = write.
- DATA_READY  out  1  one-cycle completion pulse.
- INOUT_DATA  inout  DATA_WIDTH  write data from the core; read data from the responder.
- err  out  1  one-cycle pulse, coincident with DATA_READY, on a misaligned or out-of-range access.
- busy  out  1  high in WAIT and RESP.
- rd_count  out  CNT_WIDTH  completed reads, error reads included.
- wr_count  out  CNT_WIDTH  completed writes, error writes included.

Behaviour:
- Reset (rst==0 at a rising edge):
  - FSM goes to IDLE.
  - DATA_READY=0, err=0, busy=0, rd_count=0, wr_count=0.
  - INOUT_DATA released to high impedance.
  - Wait counter cleared.
  - Array contents are not cleared; simulation initial content is all zeros.
  - Reset mid-transaction aborts it: no write commit, no DATA_READY.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If ENABLE==1 at the edge, latch ADDRESS, READNOTWRITE and, for writes, INOUT_DATA.
  - Load wait counter with LATENCY.
  - Go to WAIT if LATENCY>0, else RESP.
- WAIT:
  - Counter decrements each cycle; at count 1, go to RESP.
  - If ENABLE==0 at any WAIT edge, abort to IDLE: no commit, no DATA_READY, counters unchanged.
- Transition into RESP (commit edge):
  - Write: store latched data at word index ADDRESS[log2(DEPTH_WORDS)+1:2].
  - Read: register array[word index] into the read-data register. A read sees every write committed on earlier edges.
- RESP (exactly one cycle):
  - DATA_READY=1.
  - For reads, INOUT_DATA drives the read-data register; otherwise it is high impedance.
  - Increment rd_count or wr_count.
  - Next state is always IDLE.
- Latency: request accepted at edge k gives DATA_READY high during cycle k+1+LATENCY.
  - Back-to-back: if ENABLE is still high in the IDLE cycle after RESP, it is accepted as a new request. Minimum period is LATENCY+2 cycles.
- Error conditions:
  - ADDRESS[1:0]!=0 → misaligned.
  - ADDRESS>>2 >= DEPTH_WORDS → out of range.
  - On either: write is not committed, read returns all zeros, err=1 during RESP. The handshake completes normally.
- Bus rules:
  - Never drive INOUT_DATA outside RESP-read. No cycle exists in which both ends drive.
  - Write data is sampled only at the accept edge; later bus changes are ignored.
- Counters wrap modulo 2^CNT_WIDTH.
- Changes to ADDRESS or READNOTWRITE after acceptance are ignored.

Test Plan:
- LATENCY=2: write 0xDEADBEEF to 0x10 (ENABLE high at edge 0) → DATA_READY only in cycle 3, bus Z throughout; read 0x10 → DATA_READY in cycle 3 of that transaction, INOUT_DATA=0xDEADBEEF, wr_count=1, rd_count=1.
- LATENCY=0: back-to-back write 0x0000_0001 to 0x20 then read 0x20 with ENABLE held high → ready pulses two cycles apart, read returns 0x00000001.
- Misaligned read of 0x13 and out-of-range write to 0x1000 (DEPTH_WORDS=1024) → err=1 with DATA_READY, read data 0x00000000, word 0 not modified.
- ENABLE dropped in WAIT during a write of 0x12345678 to 0x40 → no DATA_READY, wr_count unchanged, later read of 0x40 returns the prior value.
- rst=0 asserted in WAIT during a read → next cycle IDLE, DATA_READY=0, bus Z, counters 0; array data written earlier is still readable.
- Write data changed on INOUT_DATA after acceptance (0xAAAA_AAAA then 0x5555_5555) → stored value is 0xAAAAAAAA.
